// File: rtl/fir_tap_loader.sv
// fir_tap_loader: buffers signed samples in a small FIFO and presents an 8-tap delay line to the DA core, held for FRAME_CYCLES clocks.
// Latency: a sample accepted into an empty idle block is on x1_bit two edges later, together with frame_start.
// Backpressure: in_ready = !full (0 while reset is low); sustained drain rate is one sample per FRAME_CYCLES clocks.
// Option macro FIR_TAP_LOADER_PRIME_EN: suppress frame_start/frame_busy until eight samples have been shifted in.
module fir_tap_loader #(
  parameter int DATA_W       = 8,
  parameter int FRAME_CYCLES = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk3,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           x1_bit,
  output logic [DATA_W-1:0]           x2_bit,
  output logic [DATA_W-1:0]           x3_bit,
  output logic [DATA_W-1:0]           x4_bit,
  output logic [DATA_W-1:0]           x5_bit,
  output logic [DATA_W-1:0]           x6_bit,
  output logic [DATA_W-1:0]           x7_bit,
  output logic [DATA_W-1:0]           x8_bit,
  output logic                        frame_start,
  output logic                        frame_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // FIFO storage and pointers (power-of-two depth, pointers wrap naturally)
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rdy_en;
  logic              push_vld;
  logic              pop_vld;

  // Frame control
  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic              frame_end;
  logic              start_ok;
  logic              primed;

  // Delay line, index 0 is the newest sample
  logic [DATA_W-1:0] taps [8];

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  // rdy_en holds in_ready low during reset and releases it one edge after reset rises
  assign in_ready   = rdy_en && !fifo_full;
  assign push_vld   = in_valid && in_ready;
  // A new sample is taken when idle or on the last cycle of the current frame
  assign frame_end  = (state == IDLE) || (cnt == '0);
  assign pop_vld    = !fifo_empty && frame_end;
  assign fifo_level = level;

`ifdef FIR_TAP_LOADER_PRIME_EN
  logic [3:0] fill_cnt;

  // Count shifts up to 8 so the DA core only sees full delay lines
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      fill_cnt <= 4'd0;
    end else if (pop_vld && (fill_cnt != 4'd8)) begin
      fill_cnt <= fill_cnt + 4'd1;
    end
  end

  // The shift that brings the count to 8 (or any later one) opens a visible frame
  assign start_ok = (fill_cnt >= 4'd7);
  assign primed   = (fill_cnt == 4'd8);
`else
  assign start_ok = 1'b1;
  assign primed   = 1'b1;
`endif

  assign frame_busy = (state == HOLD) && primed;

  // Sample storage; contents need no reset because level gates every read
  always_ff @(posedge clk3) begin
    if (push_vld) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and the post-reset ready enable
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push_vld) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_vld) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_vld, pop_vld})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // IDLE/HOLD sequencing with the per-frame down counter and registered frame_start
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pop_vld && start_ok;
      if (pop_vld) begin
        state <= HOLD;
        cnt   <= CNT_LOAD;
      end else if (state == HOLD) begin
        if (cnt == '0) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  // Delay line moves only on pop edges, so taps are stable for a whole frame
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        taps[i] <= '0;
      end
    end else if (pop_vld) begin
      for (int i = 7; i > 0; i--) begin
        taps[i] <= taps[i-1];
      end
      taps[0] <= mem[rd_ptr];
    end
  end

  assign x1_bit = taps[0];
  assign x2_bit = taps[1];
  assign x3_bit = taps[2];
  assign x4_bit = taps[3];
  assign x5_bit = taps[4];
  assign x6_bit = taps[5];
  assign x7_bit = taps[6];
  assign x8_bit = taps[7];

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader: queue/array reference model checked every cycle plus directed literal checks.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
// Build with FIR_TAP_LOADER_PRIME_EN defined to exercise the priming variant.
module tb_fir_tap_loader;

  localparam int DW    = 8;
  localparam int FRAME = 16;
  localparam int DEPTH = 4;
`ifdef FIR_TAP_LOADER_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic          clk3 = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit;
  logic          frame_start;
  logic          frame_busy;
  logic [$clog2(DEPTH):0] fifo_level;

  int tests = 0;
  int fails = 0;

  fir_tap_loader #(.DATA_W(DW), .FRAME_CYCLES(FRAME), .FIFO_DEPTH(DEPTH)) dut (
    .clk3(clk3), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x1_bit(x1_bit), .x2_bit(x2_bit), .x3_bit(x3_bit), .x4_bit(x4_bit),
    .x5_bit(x5_bit), .x6_bit(x6_bit), .x7_bit(x7_bit), .x8_bit(x8_bit),
    .frame_start(frame_start), .frame_busy(frame_busy), .fifo_level(fifo_level)
  );

  always #5 clk3 = ~clk3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of buffered samples, tap array, cycles left in the current frame.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mt[8] = '{default: '0};
  int m_left   = 0;
  bit m_rdy_en = 1'b0;
  bit m_start  = 1'b0;
  int m_fill   = 0;
  int m_pops   = 0;

  always @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      mq.delete();
      for (int i = 0; i < 8; i++) mt[i] = '0;
      m_left   = 0;
      m_rdy_en = 1'b0;
      m_start  = 1'b0;
      m_fill   = 0;
    end else begin
      bit acc;
      bit popd;
      acc  = in_valid && m_rdy_en && (mq.size() < DEPTH);
      popd = (mq.size() > 0) && (m_left <= 1);
      m_start = 1'b0;
      if (popd) begin
        for (int i = 7; i > 0; i--) mt[i] = mt[i-1];
        mt[0] = mq.pop_front();
        m_left = FRAME;
        m_pops++;
        if (m_fill < 8) m_fill++;
        m_start = !PRIME || (m_fill >= 8);
      end else if (m_left > 0) begin
        m_left--;
      end
      if (acc) mq.push_back(in_data);
      m_rdy_en = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk3) begin
    chk("in_ready",    64'(in_ready),    64'(m_rdy_en && (mq.size() < DEPTH)));
    chk("fifo_level",  64'(fifo_level),  64'(mq.size()));
    chk("frame_start", 64'(frame_start), 64'(m_start));
    chk("frame_busy",  64'(frame_busy),  64'((m_left > 0) && (!PRIME || m_fill >= 8)));
    chk("taps", {x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit},
                {mt[0], mt[1], mt[2], mt[3], mt[4], mt[5], mt[6], mt[7]});
  end

  // Log of every frame_start pulse: cycle number, newest tap, whole tap vector
  int cyc = 0;
  int st_cyc[$];
  logic [DW-1:0] st_x1[$];
  logic [63:0] st_taps[$];

  always @(negedge clk3) begin
    cyc++;
    if (frame_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_x1.push_back(x1_bit);
      st_taps.push_back({x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk3);
    #2;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin
      @(negedge clk3);
      k++;
    end
    chk("start_timeout", 64'(st_cyc.size() >= n), 64'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((frame_busy !== 1'b0 || fifo_level !== '0) && k < 200) begin
      @(negedge clk3);
      k++;
    end
    chk("idle_timeout", 64'(k < 200), 64'(1));
  endtask

  // Push first..last holding in_valid; advance data only when the handshake fires
  task automatic push_seq(input int first, input int last, output int max_lvl, output int nr_cnt);
    int v = first;
    int g = 0;
    bit r;
    max_lvl = 0;
    nr_cnt  = 0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'(v);
    while (v <= last && g < 1000) begin
      r = in_ready;
      if (!r) nr_cnt++;
      tick();
      g++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (r) begin
        v++;
        in_data = 8'(v);
      end
    end
    in_valid = 1'b0;
    chk("push_seq_done", 64'(v > last), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;
    int mx;
    int nr;
    int pops0;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    // Reset state with a pushing producer
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk3);
    chk("rst_in_ready",    64'(in_ready), 64'(0));
    chk("rst_fifo_level",  64'(fifo_level), 64'(0));
    chk("rst_frame_start", 64'(frame_start), 64'(0));
    chk("rst_frame_busy",  64'(frame_busy), 64'(0));
    chk("rst_taps", {x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit}, 64'(0));
    @(posedge clk3);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk3);
    @(negedge clk3);
    chk("rel_in_ready", 64'(in_ready), 64'(1));

`ifdef FIR_TAP_LOADER_PRIME_EN
    // Priming: first visible frame only once the delay line is full
    base = st_cyc.size();
    push_seq(1, 9, mx, nr);
    chk("prime_max_level", 64'(mx), 64'(4));
    wait_starts(base + 2, 400);
    if (st_cyc.size() >= base + 2) begin
      chk("prime_first_taps",  st_taps[base],     64'h0807060504030201);
      chk("prime_second_taps", st_taps[base + 1], 64'h0908070605040302);
      chk("prime_gap", 64'(st_cyc[base + 1] - st_cyc[base]), 64'(FRAME));
    end
    repeat (40) @(negedge clk3);
    chk("prime_start_count", 64'(st_cyc.size() - base), 64'(2));
`else
    // Single sample into an idle block
    tick();
    in_valid = 1'b1;
    in_data  = 8'd5;
    tick();
    in_valid = 1'b0;
    @(negedge clk3);
    chk("one_level_after_push", 64'(fifo_level), 64'(1));
    chk("one_no_start_yet",     64'(frame_start), 64'(0));
    @(negedge clk3);
    chk("one_x1",    64'(x1_bit), 64'(5));
    chk("one_x2",    64'(x2_bit), 64'(0));
    chk("one_start", 64'(frame_start), 64'(1));
    n = 1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk3);
      if (frame_busy !== 1'b1) break;
      n++;
    end
    chk("one_busy_len", 64'(n), 64'(FRAME));
    chk("one_x1_after", 64'(x1_bit), 64'(5));

    // Signed values and shift order, pushed back-to-back
    base = st_cyc.size();
    tick();
    in_valid = 1'b1;
    in_data  = 8'h80;
    tick();
    in_data  = 8'h7F;
    tick();
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    wait_starts(base + 3, 100);
    chk("sgn_x1", 64'(x1_bit), 64'h FF);
    chk("sgn_x2", 64'(x2_bit), 64'h 7F);
    chk("sgn_x3", 64'(x3_bit), 64'h 80);
    chk("sgn_x4", 64'(x4_bit), 64'd5);
    if (st_cyc.size() >= base + 3) begin
      chk("sgn_gap1", 64'(st_cyc[base + 1] - st_cyc[base]), 64'(FRAME));
      chk("sgn_gap2", 64'(st_cyc[base + 2] - st_cyc[base + 1]), 64'(FRAME));
    end
    wait_idle();

    // FIFO full: 1..10 with in_valid held high
    base  = st_cyc.size();
    pops0 = m_pops;
    push_seq(1, 10, mx, nr);
    chk("full_max_level", 64'(mx), 64'(4));
    chk("full_saw_not_ready", 64'(nr > 0), 64'(1));
    wait_starts(base + 10, 300);
    if (st_cyc.size() >= base + 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("full_order", 64'(st_x1[base + i]), 64'(i + 1));
        if (i > 0) chk("full_gap", 64'(st_cyc[base + i] - st_cyc[base + i - 1]), 64'(FRAME));
      end
    end
    repeat (40) @(negedge clk3);
    chk("full_frame_count", 64'(st_cyc.size() - base), 64'(10));
    chk("full_model_pops",  64'(m_pops - pops0), 64'(10));

    // Reset in frame cycle 7 with two samples buffered
    base = st_cyc.size();
    push_seq(11, 13, mx, nr);
    repeat (7) @(negedge clk3);
    chk("mid_level_before", 64'(fifo_level), 64'(2));
    chk("mid_busy_before",  64'(frame_busy), 64'(1));
    chk("mid_x1_before",    64'(x1_bit), 64'd11);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_async_x1",    64'(x1_bit), 64'(0));
    chk("mid_async_x2",    64'(x2_bit), 64'(0));
    chk("mid_async_level", 64'(fifo_level), 64'(0));
    chk("mid_async_busy",  64'(frame_busy), 64'(0));
    chk("mid_async_ready", 64'(in_ready), 64'(0));
    @(posedge clk3);
    @(posedge clk3);
    #2;
    reset = 1'b1;
    repeat (40) @(negedge clk3);
    chk("mid_no_start", 64'(st_cyc.size() - base), 64'(1));
    tick();
    in_valid = 1'b1;
    in_data  = 8'd21;
    tick();
    in_valid = 1'b0;
    wait_starts(base + 2, 20);
    chk("mid_new_x1", 64'(x1_bit), 64'd21);
    chk("mid_new_x2", 64'(x2_bit), 64'(0));
`endif

    repeat (4) @(negedge clk3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end

endmodule
